// File: rtl/wide_add_sequencer_pkg.sv
// wide_add_pkg: shared FSM state type and default geometry for the wide adder sequencer
package wide_add_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int DEF_SIZE = 32;
    localparam int DEF_WORDS = 4;
endpackage

// File: rtl/wide_add_sequencer_if.sv
// wide_add_sequencer_if: operand/result handshake bundle for the wide adder sequencer
interface wide_add_sequencer_if
    import wide_add_pkg::*;
#(
    parameter int SIZE = DEF_SIZE,
    parameter int WORDS = DEF_WORDS
);
    localparam int W = WORDS * SIZE;
    logic in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [W-1:0] a, b, sum;
    modport master (
        output in_valid, a, b, cin, out_ready,
        input in_ready, out_valid, sum, cout, busy
    );
    modport slave (
        input in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/sklansky_adder.sv
// sklansky_adder: parallel-prefix adder with the carry-in folded in as prefix position 0
module sklansky_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             cout,
    output logic [WIDTH-1:0] y
);
    localparam int LV = $clog2(WIDTH + 1);
    always_comb begin
        logic [WIDTH:0] g;
        logic [WIDTH:0] p;
        g = {a & b, cin};
        p = {a ^ b, 1'b0};
        // each upper half-block merges with the top of its lower half, which is untouched this level
        for (int l = 0; l < LV; l++)
            for (int i = 0; i <= WIDTH; i++)
                if (((i >> l) & 1) == 1) begin
                    g[i] = g[i] | (p[i] & g[((i >> l) << l) - 1]);
                    p[i] = p[i] & p[((i >> l) << l) - 1];
                end
        y = a ^ b ^ g[WIDTH-1:0];
        cout = g[WIDTH];
    end
endmodule

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: adds two WORDS*SIZE operands one SIZE-bit word per cycle through a shared adder
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int SIZE = DEF_SIZE,
    parameter int WORDS = DEF_WORDS
) (
    input logic clk,
    input logic rst,
    wide_add_sequencer_if.slave bus
);
    localparam int W = WORDS * SIZE;
    localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
    state_t state, state_nx;
    logic [IW-1:0] idx;
    logic [W-1:0] a_q, b_q, sum_q;
    logic carry, cout_q, add_co, accept, last;
    logic [SIZE-1:0] add_y;
    assign accept = bus.in_valid && state == IDLE;
    assign last = idx == IW'(WORDS - 1);
    sklansky_adder #(.WIDTH(SIZE)) u_add (
        .a(a_q[idx*SIZE +: SIZE]),
        .b(b_q[idx*SIZE +: SIZE]),
        .cin(carry),
        .cout(add_co),
        .y(add_y)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            carry <= 1'b0;
            sum_q <= '0;
            cout_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_q <= bus.a;
                b_q <= bus.b;
                carry <= bus.cin;
                idx <= '0;
                sum_q <= '0;
                cout_q <= 1'b0;
            end else if (state == RUN) begin
                sum_q[idx*SIZE +: SIZE] <= add_y;
                carry <= add_co;
                if (last)
                    cout_q <= add_co;
                else
                    idx <= idx + 1'b1;
            end
        end
    end
    always_comb begin
        state_nx = state == IDLE ? (bus.in_valid ? RUN : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) :
                   (bus.out_ready ? IDLE : DONE);
    end
    always_comb begin
        bus.in_ready = state == IDLE;
        bus.busy = state == RUN;
        bus.out_valid = state == DONE;
        bus.sum = sum_q;
        bus.cout = cout_q;
    end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer: directed and random checks of a 4-word and a 1-word sequencer against an a+b+cin model
module tb_wide_add_sequencer;
    localparam int S = 32;
    localparam logic [127:0] ONES = '1;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic iv[2], icin[2], ordy[2], ir[2], ov[2], by[2], co[2];
    logic [127:0] ia[2], ib[2], sm[2];
    logic pend[2];
    int rdy[2], ndone[2];
    logic [127:0] es[2];
    logic ec[2];
    int cyc = 0;
    int errs = 0;
    int checks = 0;
    always #5 clk = ~clk;
    wide_add_sequencer_if #(.SIZE(S), .WORDS(4)) b4 ();
    wide_add_sequencer_if #(.SIZE(S), .WORDS(1)) b1 ();
    wide_add_sequencer #(.SIZE(S), .WORDS(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    wide_add_sequencer #(.SIZE(S), .WORDS(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    assign b4.in_valid = iv[0];
    assign b4.a = ia[0];
    assign b4.b = ib[0];
    assign b4.cin = icin[0];
    assign b4.out_ready = ordy[0];
    assign b1.in_valid = iv[1];
    assign b1.a = ia[1][31:0];
    assign b1.b = ib[1][31:0];
    assign b1.cin = icin[1];
    assign b1.out_ready = ordy[1];
    assign ir[0] = b4.in_ready;
    assign ov[0] = b4.out_valid;
    assign by[0] = b4.busy;
    assign co[0] = b4.cout;
    assign sm[0] = b4.sum;
    assign ir[1] = b1.in_ready;
    assign ov[1] = b1.out_valid;
    assign by[1] = b1.busy;
    assign co[1] = b1.cout;
    assign sm[1] = {96'b0, b1.sum};

    function automatic int wn(int k);
        return k == 0 ? 4 : 1;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(int k, string n, logic [128:0] act, logic [128:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s (words=%0d) t=%0t: got %0h expected %0h", n, wn(k), $time, act, exp);
        end
    endtask

    // model: one outstanding op per instance, result ready WORDS edges after the accepting edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) pend[k] = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (pend[k] && cyc >= rdy[k] && ordy[k]) begin
                    pend[k] = 1'b0;
                    ndone[k]++;
                end else if (!pend[k] && iv[k]) begin
                    logic [128:0] s;
                    s = k == 0 ? {1'b0, ia[k]} + {1'b0, ib[k]} + 129'(icin[k])
                               : 129'({1'b0, ia[k][31:0]} + {1'b0, ib[k][31:0]} + 33'(icin[k]));
                    pend[k] = 1'b1;
                    rdy[k] = cyc + 1 + wn(k);
                    es[k] = k == 0 ? s[127:0] : {96'b0, s[31:0]};
                    ec[k] = k == 0 ? s[128] : s[32];
                end
            end
            cyc++;
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            chk(k, "in_ready", ir[k], !pend[k]);
            chk(k, "busy", by[k], pend[k] && cyc < rdy[k]);
            chk(k, "out_valid", ov[k], pend[k] && cyc >= rdy[k]);
            if (pend[k] && cyc >= rdy[k]) begin
                chk(k, "sum", sm[k], es[k]);
                chk(k, "cout", co[k], ec[k]);
            end
        end
    end

    task automatic run(int k, logic [127:0] a, logic [127:0] b, logic c,
                       logic [127:0] xs, logic xc, int hold);
        int lat = 0;
        chk(k, "pre_in_ready", ir[k], 1);
        iv[k] = 1'b1;
        ia[k] = a;
        ib[k] = b;
        icin[k] = c;
        @(negedge clk);
        iv[k] = 1'b0;
        ia[k] = rnd128();
        ib[k] = rnd128();
        icin[k] = ~c;
        while (!ov[k] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk(k, "latency", lat, wn(k));
        chk(k, "lit_sum", sm[k], xs);
        chk(k, "lit_cout", co[k], xc);
        for (int i = 0; i < hold; i++) begin
            ia[k] = rnd128();
            ib[k] = rnd128();
            @(negedge clk);
            chk(k, "hold_sum", sm[k], xs);
            chk(k, "hold_cout", co[k], xc);
            chk(k, "hold_in_ready", ir[k], 0);
            chk(k, "hold_valid", ov[k], 1);
        end
        ordy[k] = 1'b1;
        @(negedge clk);
        ordy[k] = 1'b0;
        chk(k, "post_valid", ov[k], 0);
        chk(k, "post_in_ready", ir[k], 1);
    endtask

    task automatic rnd_ops(int k, int n);
        int base = ndone[k];
        int guard = 0;
        while (ndone[k] - base < n && guard < 30000) begin
            iv[k] = $urandom_range(0, 2) != 0;
            ia[k] = $urandom_range(0, 7) == 0 ? ONES : rnd128();
            ib[k] = $urandom_range(0, 7) == 0 ? ONES : rnd128();
            icin[k] = 1'($urandom);
            ordy[k] = $urandom_range(0, 3) != 0;
            @(negedge clk);
            guard++;
        end
        chk(k, "ops_done", ndone[k] - base >= n, 1);
        iv[k] = 1'b0;
        ordy[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0;
            icin[k] = 1'b0;
            ordy[k] = 1'b0;
            ia[k] = '0;
            ib[k] = '0;
            pend[k] = 1'b0;
            rdy[k] = 0;
            ndone[k] = 0;
            es[k] = '0;
            ec[k] = 1'b0;
        end
        #1 rst = 1'b1;
        repeat (3) begin
            for (int k = 0; k < 2; k++) begin
                iv[k] = 1'($urandom);
                ia[k] = rnd128();
                ib[k] = rnd128();
                icin[k] = 1'($urandom);
                ordy[k] = 1'($urandom);
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk(k, "rst_in_ready", ir[k], 1);
                chk(k, "rst_out_valid", ov[k], 0);
                chk(k, "rst_busy", by[k], 0);
                chk(k, "rst_sum", sm[k], 0);
                chk(k, "rst_cout", co[k], 0);
            end
        end
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0;
            ordy[k] = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);
        run(0, 128'd1, 128'd2, 1'b0, 128'd3, 1'b0, 0);
        run(0, ONES, 128'd0, 1'b1, 128'd0, 1'b1, 0);
        run(0, ONES, ONES, 1'b1, ONES, 1'b1, 10);
        run(0, 128'h0000_0001_FFFF_FFFF_0000_0000_FFFF_FFFF, 128'd1, 1'b0,
            128'h0000_0001_FFFF_FFFF_0000_0001_0000_0000, 1'b0, 2);
        run(1, 128'hFFFF_FFFF, 128'd0, 1'b1, 128'd0, 1'b1, 3);
        run(1, 128'd5, 128'd7, 1'b1, 128'd13, 1'b0, 0);
        iv[0] = 1'b1;
        ia[0] = ONES;
        ib[0] = 128'd1;
        icin[0] = 1'b0;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk(0, "abort_in_ready", ir[0], 1);
        chk(0, "abort_busy", by[0], 0);
        chk(0, "abort_out_valid", ov[0], 0);
        chk(0, "abort_sum", sm[0], 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk(0, "abort_no_result", ov[0], 0);
        end
        run(0, 128'd5, 128'd7, 1'b0, 128'd12, 1'b0, 0);
        fork
            rnd_ops(0, 1000);
            rnd_ops(1, 1000);
        join
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
